spi_ctrl: RTL and testbench

SPI_CTRL -- requirements
Module: spi_ctrl

---
 rtl/spi_pkg.sv | 31 +++
 rtl/spi_ctrl.sv | 154 +++++++++++++++
 tb/tb_spi_ctrl.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// ============================================================================
// Module  : spi_pkg
// Brief   : Shared constants and state encoding for the SPI memory controller
//           and its memory-slave bench.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package spi_pkg;

    localparam logic OP_WR   = 1'b1;
    localparam logic OP_RD   = 1'b0;
    localparam int   ADDR_W  = 8;
    localparam int   DATA_W  = 8;
    localparam int   TIMEOUT = 32;

    localparam int   SR_W    = ADDR_W + DATA_W;
    localparam int   TMO_W   = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        OPBIT     = 3'd1,
        SHIFT     = 3'd2,
        WAIT_RDY  = 3'd3,
        RECV      = 3'd4,
        WAIT_DONE = 3'd5
    } spi_state_e;

endpackage

`default_nettype wire

// File: rtl/spi_ctrl.sv
// ============================================================================
// Module  : spi_ctrl
// Brief   : SPI master for a serial memory slave; one 16-bit shift register
//           carries addr/data out and read data back in.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_ctrl
    import spi_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              newd,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    output logic              cs,
    output logic              miso,
    input  logic              mosi,
    input  logic              ready,
    input  logic              op_done,
    output logic [DATA_W-1:0] dout,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [3:0] c_WR_LAST   = 4'(SR_W - 1);
    localparam logic [3:0] c_RD_LAST   = 4'(ADDR_W - 1);
    localparam logic [3:0] c_RECV_LAST = 4'(DATA_W - 1);
    localparam logic [3:0] c_OP_LAST   = 4'd1;

    spi_state_e        r_state;
    logic              r_wr;
    logic [SR_W-1:0]   r_sr;
    logic [3:0]        r_bit;
    logic [TMO_W-1:0]  r_tmo;
    logic              r_cs;
    logic              r_miso;
    logic [DATA_W-1:0] r_dout;
    logic              r_done;
    logic              r_err;

    logic [3:0]        w_last_bit;

    assign w_last_bit = (r_wr == OP_WR) ? c_WR_LAST : c_RD_LAST;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_wr    <= 1'b0;
            r_sr    <= '0;
            r_bit   <= '0;
            r_tmo   <= '0;
            r_cs    <= 1'b1;
            r_miso  <= 1'b0;
            r_dout  <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (newd) begin
                        r_state <= OPBIT;
                        r_wr    <= wr;
                        r_sr    <= {din, addr};
                        r_bit   <= '0;
                        r_tmo   <= '0;
                        r_cs    <= 1'b0;
                        r_miso  <= wr;
                    end
                end
                OPBIT: begin
                    // Op bit is held for two cycles so the slave samples it on the second.
                    if (r_bit == c_OP_LAST) begin
                        r_state <= SHIFT;
                        r_bit   <= '0;
                        r_miso  <= r_sr[0];
                        r_sr    <= {1'b0, r_sr[SR_W-1:1]};
                    end else begin
                        r_bit <= r_bit + 4'd1;
                    end
                end
                SHIFT: begin
                    if (r_bit == w_last_bit) begin
                        r_state <= (r_wr == OP_WR) ? WAIT_DONE : WAIT_RDY;
                        r_bit   <= '0;
                        r_tmo   <= '0;
                        r_cs    <= 1'b1;
                        r_miso  <= 1'b0;
                    end else begin
                        r_bit  <= r_bit + 4'd1;
                        r_miso <= r_sr[0];
                        r_sr   <= {1'b0, r_sr[SR_W-1:1]};
                    end
                end
                WAIT_RDY: begin
                    if (ready) begin
                        r_state <= RECV;
                        r_bit   <= '0;
                    end else if (r_tmo == TMO_W'(TIMEOUT)) begin
                        r_state <= IDLE;
                        r_err   <= 1'b1;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                RECV: begin
                    r_sr[DATA_W-1:0] <= {mosi, r_sr[DATA_W-1:1]};
                    if (r_bit == c_RECV_LAST) begin
                        r_state <= WAIT_DONE;
                        r_bit   <= '0;
                        r_tmo   <= '0;
                    end else begin
                        r_bit <= r_bit + 4'd1;
                    end
                end
                WAIT_DONE: begin
                    // Read data is only committed once the slave confirms completion.
                    if (op_done) begin
                        r_state <= IDLE;
                        r_done  <= 1'b1;
                        if (r_wr == OP_RD) begin
                            r_dout <= r_sr[DATA_W-1:0];
                        end
                    end else if (r_tmo == TMO_W'(TIMEOUT)) begin
                        r_state <= IDLE;
                        r_err   <= 1'b1;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cs    <= 1'b1;
                    r_miso  <= 1'b0;
                end
            endcase
        end
    end

    assign cs   = r_cs;
    assign miso = r_miso;
    assign dout = r_dout;
    assign busy = (r_state != IDLE);
    assign done = r_done;
    assign err  = r_err;

endmodule

`default_nettype wire

// File: tb/tb_spi_ctrl.sv
// ============================================================================
// Module  : tb_spi_ctrl
// Brief   : Self-checking bench for spi_ctrl with an in-bench memory slave and
//           a cycle-indexed reference of the transaction timeline.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_ctrl;

    logic       clk;
    logic       rst;
    logic       newd;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] din;
    logic       cs;
    logic       miso;
    logic       mosi;
    logic       ready;
    logic       op_done;
    logic [7:0] dout;
    logic       busy;
    logic       done;
    logic       err;

    int n_checks;
    int n_errors;

    logic [7:0] ref_mem   [256];
    logic [7:0] slave_mem [256];
    logic [7:0] exp_dout;

    spi_ctrl u_dut (
        .clk     (clk),
        .rst     (rst),
        .newd    (newd),
        .wr      (wr),
        .addr    (addr),
        .din     (din),
        .cs      (cs),
        .miso    (miso),
        .mosi    (mosi),
        .ready   (ready),
        .op_done (op_done),
        .dout    (dout),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int k, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s t%0d: observed 0x%0h expected 0x%0h", tag, k, got, exp);
        end
    endtask

    // One transaction: cycle k=0 is the newd cycle; the bench plays the slave.
    // ok=0 models a slave held in reset (never answers); dly delays the
    // slave's ready (read) or op_done (write); rst_at>=0 resets the DUT in that cycle.
    task automatic do_txn(input logic w, input logic [7:0] a, input logic [7:0] d,
                          input bit ok, input int dly, input int rst_at);
        int          last, rdy_t, op_t, done_t, err_t, end_t, stop_t;
        logic [15:0] pay;
        logic [15:0] slv_bits;
        logic        slv_op;
        logic [7:0]  new_dout;
        logic        e_cs, e_miso, e_busy, e_done, e_err;
        logic [7:0]  e_dout;

        pay      = {d, a};
        slv_bits = '0;
        slv_op   = 1'b0;
        last     = w ? 18 : 10;
        if (w) begin
            rdy_t = -100;
            op_t  = 20 + dly;
        end else begin
            rdy_t = 12 + dly;
            op_t  = rdy_t + 9;
        end
        done_t   = op_t + 1;
        err_t    = w ? 52 : 44;
        end_t    = ok ? done_t : err_t;
        stop_t   = (rst_at >= 0) ? rst_at + 2 : end_t + 1;
        new_dout = (ok && !w) ? ref_mem[a] : exp_dout;

        for (int k = 0; k <= stop_t; k++) begin
            newd = (k == 0) || (k == 6);
            if (k == 0) begin
                wr   = w;
                addr = a;
                din  = d;
            end else begin
                wr   = 1'($urandom);
                addr = 8'($urandom);
                din  = 8'($urandom);
            end
            rst     = (k == rst_at);
            ready   = (ok && k == rdy_t) || (k == 4) || (w && k == 19);
            op_done = (ok && k == op_t) || (k == 4) || (!w && k == 11);
            if (ok && !w && k > rdy_t && k <= rdy_t + 8)
                mosi = slave_mem[slv_bits[7:0]][k - rdy_t - 1];
            else
                mosi = 1'($urandom);

            @(negedge clk);
            if (rst_at >= 0 && k > rst_at) begin
                e_cs = 1'b1; e_miso = 1'b0; e_busy = 1'b0;
                e_done = 1'b0; e_err = 1'b0; e_dout = 8'h00;
            end else begin
                e_cs   = !(k >= 1 && k <= last);
                if (k == 1 || k == 2)
                    e_miso = w;
                else if (k >= 3 && k <= last)
                    e_miso = pay[k - 3];
                else
                    e_miso = 1'b0;
                e_busy = (k >= 1 && k < end_t);
                e_done = ok && (k == done_t);
                e_err  = !ok && (k == err_t);
                e_dout = (k >= end_t) ? new_dout : exp_dout;
            end
            chk("cs",   k, 8'(cs),   8'(e_cs));
            chk("miso", k, 8'(miso), 8'(e_miso));
            chk("busy", k, 8'(busy), 8'(e_busy));
            chk("done", k, 8'(done), 8'(e_done));
            chk("err",  k, 8'(err),  8'(e_err));
            chk("dout", k, dout,     e_dout);

            if (!cs && k == 2) slv_op = miso;
            if (!cs && k >= 3 && k <= last) slv_bits[k - 3] = miso;
            if (k == last && w && slv_op && rst_at < 0 && ok)
                slave_mem[slv_bits[7:0]] = slv_bits[15:8];

            @(posedge clk); #1;
        end

        newd = 1'b0; rst = 1'b0; ready = 1'b0; op_done = 1'b0;
        if (rst_at >= 0) begin
            exp_dout = 8'h00;
        end else begin
            exp_dout = new_dout;
            if (w && ok) ref_mem[a] = d;
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_dout = 8'h00;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        exp_dout = 8'h00;
        for (int i = 0; i < 256; i++) begin
            ref_mem[i]   = 8'h00;
            slave_mem[i] = 8'h00;
        end
        rst = 1'b1; newd = 1'b1; wr = 1'b1; addr = 8'h11; din = 8'h22;
        mosi = 1'b1; ready = 1'b1; op_done = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cs",   0, 8'(cs),   8'h01);
        chk("rst_miso", 0, 8'(miso), 8'h00);
        chk("rst_busy", 0, 8'(busy), 8'h00);
        chk("rst_done", 0, 8'(done), 8'h00);
        chk("rst_err",  0, 8'(err),  8'h00);
        chk("rst_dout", 0, dout,     8'h00);
        @(posedge clk); #1;
        rst = 1'b0; newd = 1'b0; ready = 1'b0; op_done = 1'b0;

        do_txn(1'b1, 8'h05, 8'hA5, 1'b1, 0, -1);
        do_txn(1'b0, 8'h05, 8'h00, 1'b1, 0, -1);
        pulse_reset();
        do_txn(1'b0, 8'h1F, 8'h00, 1'b1, 0, -1);
        do_txn(1'b0, 8'h05, 8'h00, 1'b1, 0, -1);
        do_txn(1'b0, 8'h05, 8'h00, 1'b0, 0, -1);
        do_txn(1'b1, 8'h09, 8'h5A, 1'b1, 0, 8);
        do_txn(1'b1, 8'h02, 8'h3C, 1'b1, 0, -1);
        do_txn(1'b0, 8'h02, 8'h00, 1'b1, 0, -1);
        do_txn(1'b0, 8'h09, 8'h00, 1'b1, 0, -1);
        do_txn(1'b0, 8'h02, 8'h00, 1'b1, 31, -1);
        do_txn(1'b1, 8'h10, 8'h77, 1'b1, 31, -1);
        do_txn(1'b0, 8'h10, 8'h00, 1'b1, 0, -1);

        for (int n = 0; n < 16; n++) begin
            logic       rw;
            logic [7:0] ra, rd;
            rw = 1'($urandom);
            ra = 8'($urandom_range(0, 15));
            rd = 8'($urandom);
            do_txn(rw, ra, rd, 1'b1, int'($urandom_range(0, 5)), -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
